hamming_decoder_ctrl: RTL

HAMMING_DECODER_CTRL -- requirements
Module: hamming_decoder_ctrl

---
 rtl/hamming_decoder_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hamming_decoder_ctrl.sv
// hamming_decoder_ctrl
// Serial Hamming(15,11) decoder controller. Counts 15 code bits into an
// external serial-in shifter, computes the syndrome for one cycle, corrects
// a single-bit error and presents the 11-bit payload on a valid/ready
// output handshake.
// Optional feature: define HAMMING_DECODER_ERR_COUNT_EN to add a saturating
// 8-bit count of frames decoded with a nonzero syndrome (port err_count).
module hamming_decoder_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic        shift,
  input  logic [14:0] word_in,
  output logic [10:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  syndrome,
  output logic        err_corrected
`ifdef HAMMING_DECODER_ERR_COUNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [3:0]  syn_c;
  logic [14:0] fixed_c;
  logic [10:0] data_c;

  // Syndrome is the XOR of the 1-based positions of all set bits.
  function automatic logic [3:0] calc_syndrome(input logic [14:0] w);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (w[i]) s = s ^ 4'(i + 1);
    end
    return s;
  endfunction

  // Flip the bit named by the syndrome; zero syndrome leaves the word alone.
  function automatic logic [14:0] correct_word(input logic [14:0] w,
                                               input logic [3:0]  s);
    logic [14:0] flip;
    flip = 15'd0;
    if (s != 4'd0) flip = 15'd1 << (s - 4'd1);
    return w ^ flip;
  endfunction

  // Payload sits at every non-power-of-two position.
  function automatic logic [10:0] extract_data(input logic [14:0] w);
    return {w[14:8], w[6:4], w[2]};
  endfunction

  assign shift   = bit_valid & bit_ready;
  assign syn_c   = calc_syndrome(word_in);
  assign fixed_c = correct_word(word_in, syn_c);
  assign data_c  = extract_data(fixed_c);

  // Frame control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= COLLECT;
      bit_cnt       <= 4'd0;
      bit_ready     <= 1'b1;
      out_valid     <= 1'b0;
      data_out      <= 11'h000;
      syndrome      <= 4'h0;
      err_corrected <= 1'b0;
`ifdef HAMMING_DECODER_ERR_COUNT_EN
      err_count     <= 8'h00;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (shift) begin
            if (bit_cnt == 4'd14) begin
              bit_cnt   <= 4'd0;
              bit_ready <= 1'b0;
              state     <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        // ---- CHECK -> OUTPUT: result registers load here ----
        CHECK: begin
          data_out      <= data_c;
          syndrome      <= syn_c;
          err_corrected <= (syn_c != 4'd0);
          out_valid     <= 1'b1;
          state         <= OUTPUT;
`ifdef HAMMING_DECODER_ERR_COUNT_EN
          if ((syn_c != 4'd0) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
`endif
        end
        // ---- OUTPUT: hold until the consumer takes the word ----
        OUTPUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            bit_ready <= 1'b1;
            state     <= COLLECT;
          end
        end
        default: begin
          state     <= COLLECT;
          bit_cnt   <= 4'd0;
          bit_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
